axil_reg_write_slave: RTL and testbench

// AXI4-Lite write-channel responder (AW/W/B only) terminating the fabric's write masters.

---
 rtl/axil_pkg.sv | 18 +
 rtl/axil_addr_decode.sv | 29 ++
 rtl/axil_reg_write_slave.sv | 146 ++++++++++++++
 tb/tb_axil_reg_write_slave.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes, slave FSM state encoding and small helpers.
// Used by both slave- and master-side blocks of the fabric.
package axil_pkg;

   localparam logic [1:0] BRESP_OKAY   = 2'b00;
   localparam logic [1:0] BRESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_RESP  = 2'd2
   } axil_state_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/axil_addr_decode.sv
// Combinational write-address decode: maps a byte address onto the register bank.
// Reg 0 is read-only, so it decodes as not-ok alongside out-of-range and misaligned addresses.
module axil_addr_decode
   import axil_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h4000_0000,
   parameter int                    NUM_REGS   = 4,
   localparam int                   IDX_W      = $clog2(NUM_REGS)
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic                  ok,
   output logic [IDX_W-1:0]      index
);

   localparam logic [ADDR_WIDTH-1:0] WINDOW = ADDR_WIDTH'(NUM_REGS * 4);

   logic [ADDR_WIDTH-1:0] offset;
   logic                  in_range;
   logic                  aligned;

   // Unsigned subtraction: addresses below BASE_ADDR wrap to huge offsets and fail the range test.
   assign offset   = addr - BASE_ADDR;
   assign in_range = (offset < WINDOW);
   assign aligned  = (addr[1:0] == 2'b00);
   assign index    = offset[IDX_W+1:2];
   assign ok       = in_range & aligned & (index != '0);

endmodule

// File: rtl/axil_reg_write_slave.sv
// AXI4-Lite write-only slave: collects AW and W in either order, updates a small register bank
// and returns BRESP. Reg 0 holds a read-only ID constant.
//
// state    | meaning
// ST_IDLE  | collecting AW / W beats; readies high for whichever beat is not yet held
// ST_WRITE | one cycle: decode, update register or flag error, raise BVALID
// ST_RESP  | holding BVALID/BRESP until BREADY
module axil_reg_write_slave
   import axil_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h4000_0000,
   parameter int                    NUM_REGS   = 4,
   parameter logic [DATA_WIDTH-1:0] REG0_ID    = 32'hA11E_0001
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
   input  logic                           S_AXI_AWVALID,
   output logic                           S_AXI_AWREADY,
   input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
   input  logic                           S_AXI_WVALID,
   output logic                           S_AXI_WREADY,
   output logic [1:0]                     S_AXI_BRESP,
   output logic                           S_AXI_BVALID,
   input  logic                           S_AXI_BREADY,
   output logic [NUM_REGS*DATA_WIDTH-1:0] regs_q,
   output logic [NUM_REGS-1:0]            wr_strobe,
   output logic [15:0]                    err_count
);

   localparam int IDX_W = $clog2(NUM_REGS);

   axil_state_t           state, state_n;
   logic                  aw_held, aw_held_n;
   logic                  w_held, w_held_n;
   logic                  awready_n, wready_n;
   logic                  bvalid_n;
   logic [1:0]            bresp_n;
   logic                  aw_fire, w_fire;
   logic                  do_write, do_err;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  dec_ok;
   logic [IDX_W-1:0]      dec_idx;
   logic [DATA_WIDTH-1:0] regs_r [1:NUM_REGS-1];

   axil_addr_decode #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .BASE_ADDR  (BASE_ADDR),
      .NUM_REGS   (NUM_REGS)
   ) u_decode (
      .addr  (addr_q),
      .ok    (dec_ok),
      .index (dec_idx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n   = state;
      aw_held_n = aw_held;
      w_held_n  = w_held;
      awready_n = 1'b0;
      wready_n  = 1'b0;
      bvalid_n  = S_AXI_BVALID;
      bresp_n   = S_AXI_BRESP;
      aw_fire   = 1'b0;
      w_fire    = 1'b0;
      do_write  = 1'b0;
      do_err    = 1'b0;
      case (state)
         ST_IDLE: begin
            aw_fire   = S_AXI_AWVALID & S_AXI_AWREADY;
            w_fire    = S_AXI_WVALID & S_AXI_WREADY;
            aw_held_n = aw_held | aw_fire;
            w_held_n  = w_held | w_fire;
            // Both beats are already held here, so both readies are low and nothing can fire.
            if (aw_held && w_held) begin
               state_n = ST_WRITE;
            end else begin
               awready_n = ~aw_held_n;
               wready_n  = ~w_held_n;
            end
         end
         ST_WRITE: begin
            bvalid_n = 1'b1;
            bresp_n  = dec_ok ? BRESP_OKAY : BRESP_SLVERR;
            do_write = dec_ok;
            do_err   = ~dec_ok;
            state_n  = ST_RESP;
         end
         ST_RESP: begin
            if (S_AXI_BREADY) begin
               bvalid_n  = 1'b0;
               aw_held_n = 1'b0;
               w_held_n  = 1'b0;
               awready_n = 1'b1;
               wready_n  = 1'b1;
               state_n   = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         aw_held       <= 1'b0;
         w_held        <= 1'b0;
         S_AXI_AWREADY <= 1'b0;
         S_AXI_WREADY  <= 1'b0;
         S_AXI_BVALID  <= 1'b0;
         S_AXI_BRESP   <= BRESP_OKAY;
         addr_q        <= '0;
         data_q        <= '0;
         wr_strobe     <= '0;
         err_count     <= '0;
         for (int i = 1; i < NUM_REGS; i++) regs_r[i] <= '0;
      end else begin
         aw_held       <= aw_held_n;
         w_held        <= w_held_n;
         S_AXI_AWREADY <= awready_n;
         S_AXI_WREADY  <= wready_n;
         S_AXI_BVALID  <= bvalid_n;
         S_AXI_BRESP   <= bresp_n;
         if (aw_fire) addr_q <= S_AXI_AWADDR;
         if (w_fire)  data_q <= S_AXI_WDATA;
         wr_strobe <= do_write ? (NUM_REGS'(1) << dec_idx) : '0;
         if (do_err) err_count <= sat_inc16(err_count);
         for (int i = 1; i < NUM_REGS; i++) begin
            if (do_write && (dec_idx == IDX_W'(i))) regs_r[i] <= data_q;
         end
      end
   end

   assign regs_q[DATA_WIDTH-1:0] = REG0_ID;
   for (genvar g = 1; g < NUM_REGS; g++) begin : g_flat
      assign regs_q[g*DATA_WIDTH +: DATA_WIDTH] = regs_r[g];
   end

endmodule

// File: tb/tb_axil_reg_write_slave.sv
// Self-checking bench for axil_reg_write_slave: directed vector table, hand-written corner
// sequences and randomized transactions against a behavioural register-bank model.
module tb_axil_reg_write_slave;

   localparam longint BASE = 64'h4000_0000;
   localparam logic [31:0] ID0 = 32'hA11E_0001;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  awaddr;
   logic         awvalid;
   logic         awready;
   logic [31:0]  wdata;
   logic         wvalid;
   logic         wready;
   logic [1:0]   bresp;
   logic         bvalid;
   logic         bready;
   logic [127:0] regs_q;
   logic [3:0]   wr_strobe;
   logic [15:0]  err_count;

   int nchk = 0;
   int nerr = 0;

   logic [31:0] mregs [4];
   int          merr;

   always #5 clk = ~clk;

   axil_reg_write_slave dut (
      .clk           (clk),
      .rst           (rst),
      .S_AXI_AWADDR  (awaddr),
      .S_AXI_AWVALID (awvalid),
      .S_AXI_AWREADY (awready),
      .S_AXI_WDATA   (wdata),
      .S_AXI_WVALID  (wvalid),
      .S_AXI_WREADY  (wready),
      .S_AXI_BRESP   (bresp),
      .S_AXI_BVALID  (bvalid),
      .S_AXI_BREADY  (bready),
      .regs_q        (regs_q),
      .wr_strobe     (wr_strobe),
      .err_count     (err_count)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          awd;
      int          wd;
      int          bwait;
      logic [1:0]  exp_resp;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [1:0] model_resp(input logic [31:0] a);
      longint x = longint'(a);
      bit ok;
      ok = (x >= BASE) && (x < BASE + 16) && ((x % 4) == 0) && (x != BASE);
      return ok ? 2'b00 : 2'b10;
   endfunction

   task automatic model_reset();
      mregs[0] = ID0;
      for (int i = 1; i < 4; i++) mregs[i] = 32'h0;
      merr = 0;
   endtask

   task automatic check_bank(input string tag);
      for (int i = 0; i < 4; i++)
         chk($sformatf("%s reg%0d", tag, i), 64'(regs_q[i*32 +: 32]), 64'(mregs[i]));
      chk({tag, " err_count"}, 64'(err_count), 64'(merr));
   endtask

   // One full write transaction; AW/W presented after awd/wd cycles, BREADY held low bwait cycles.
   // With pend set, a second AW is offered during RESP to prove it is not accepted there.
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input int awd,
                            input int wd, input int bwait, input logic [1:0] exp_resp,
                            input bit pend, input string tag);
      int cyc = 0;
      bit aw_done = 0, w_done = 0, aw_f, w_f;
      int idx;
      logic [3:0] exp_strobe;
      while (!(aw_done && w_done)) begin
         @(negedge clk);
         if (aw_done) chk({tag, " awready after AW"}, 64'(awready), 64'd0);
         if (w_done)  chk({tag, " wready after W"}, 64'(wready), 64'd0);
         awvalid = !aw_done && (cyc >= awd);
         awaddr  = addr;
         wvalid  = !w_done && (cyc >= wd);
         wdata   = data;
         aw_f = awvalid && awready;
         w_f  = wvalid && wready;
         @(posedge clk);
         if (aw_f) aw_done = 1;
         if (w_f)  w_done = 1;
         cyc++;
         if (cyc > 60) begin
            chk({tag, " handshake timeout"}, 64'(cyc), 64'd0);
            awvalid = 0;
            wvalid  = 0;
            return;
         end
      end
      @(negedge clk);
      awvalid = 0;
      wvalid  = 0;
      chk({tag, " bvalid edge+0"}, 64'(bvalid), 64'd0);
      chk({tag, " readies low"}, 64'({awready, wready}), 64'd0);
      @(negedge clk);
      chk({tag, " bvalid edge+1"}, 64'(bvalid), 64'd0);
      @(negedge clk);
      chk({tag, " bvalid edge+2"}, 64'(bvalid), 64'd1);
      chk({tag, " bresp"}, 64'(bresp), 64'(exp_resp));
      if (exp_resp == 2'b00) begin
         idx = int'((longint'(addr) - BASE) / 4);
         exp_strobe = 4'b0001 << idx;
         mregs[idx] = data;
      end else begin
         exp_strobe = 4'b0000;
         if (merr < 65535) merr++;
      end
      chk({tag, " wr_strobe"}, 64'(wr_strobe), 64'(exp_strobe));
      check_bank(tag);
      bready = 0;
      if (pend) begin
         awvalid = 1;
         awaddr  = 32'h4000_0008;
      end
      for (int i = 0; i < bwait; i++) begin
         @(negedge clk);
         chk({tag, " bvalid hold"}, 64'(bvalid), 64'd1);
         chk({tag, " bresp hold"}, 64'(bresp), 64'(exp_resp));
         chk({tag, " awready in RESP"}, 64'(awready), 64'd0);
         chk({tag, " strobe pulse"}, 64'(wr_strobe), 64'd0);
      end
      bready = 1;
      @(negedge clk);
      bready  = 0;
      awvalid = 0;
      chk({tag, " bvalid cleared"}, 64'(bvalid), 64'd0);
      chk({tag, " readies back"}, 64'({awready, wready}), 64'd3);
      chk({tag, " strobe cleared"}, 64'(wr_strobe), 64'd0);
      check_bank({tag, " post"});
   endtask

   initial begin
      vecs[0] = '{32'h4000_0004, 32'h0000_1230, 0, 0, 0, 2'b00};
      vecs[1] = '{32'h4000_000C, 32'hDEAD_BEEF, 3, 0, 0, 2'b00};
      vecs[2] = '{32'h4000_0100, 32'h1111_1111, 0, 0, 0, 2'b10};
      vecs[3] = '{32'h4000_0006, 32'h2222_2222, 0, 1, 0, 2'b10};
      vecs[4] = '{32'h4000_0000, 32'h0000_0000, 0, 0, 0, 2'b10};
      vecs[5] = '{32'h4000_0008, 32'h0000_ABCD, 0, 2, 1, 2'b00};
      vecs[6] = '{32'h3FFF_FFFC, 32'h3333_3333, 1, 0, 0, 2'b10};
      vecs[7] = '{32'h4000_0010, 32'h4444_4444, 0, 0, 2, 2'b10};
      vecs[8] = '{32'h4000_0004, 32'h0000_1230, 0, 0, 0, 2'b00};
      vecs[9] = '{32'h4000_0004, 32'h0000_1231, 1, 1, 0, 2'b00};

      rst = 1; awaddr = 0; awvalid = 0; wdata = 0; wvalid = 0; bready = 0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("reset awready", 64'(awready), 64'd0);
      chk("reset wready", 64'(wready), 64'd0);
      chk("reset bvalid", 64'(bvalid), 64'd0);
      chk("reset bresp", 64'(bresp), 64'd0);
      chk("reset strobe", 64'(wr_strobe), 64'd0);
      check_bank("reset");
      rst = 0;
      @(negedge clk);
      chk("readies after release", 64'({awready, wready}), 64'd3);

      foreach (vecs[v])
         axi_write(vecs[v].addr, vecs[v].data, vecs[v].awd, vecs[v].wd, vecs[v].bwait,
                   vecs[v].exp_resp, 1'b0, $sformatf("vec%0d", v));

      // Pending AW during a long RESP, then accepted in the next transaction
      axi_write(32'h4000_0004, 32'h0000_5555, 0, 0, 5, 2'b00, 1'b1, "pend");
      axi_write(32'h4000_0008, 32'h0000_6666, 0, 0, 0, 2'b00, 1'b0, "pend next");

      // Reset while BVALID is high
      @(negedge clk);
      awaddr = 32'h4000_000C; wdata = 32'h7777_7777; awvalid = 1; wvalid = 1;
      @(negedge clk);
      awvalid = 0; wvalid = 0;
      @(negedge clk);
      @(negedge clk);
      chk("pre-reset bvalid", 64'(bvalid), 64'd1);
      rst = 1;
      #1;
      chk("rst bvalid", 64'(bvalid), 64'd0);
      chk("rst readies", 64'({awready, wready}), 64'd0);
      model_reset();
      check_bank("rst mid");
      @(negedge clk);
      rst = 0;
      @(negedge clk);
      chk("readies after rst", 64'({awready, wready}), 64'd3);
      chk("no resp after rst", 64'(bvalid), 64'd0);

      for (int t = 0; t < 40; t++) begin
         logic [31:0] a;
         a = 32'h4000_0000 + 32'($urandom_range(0, 5) * 4);
         if ($urandom_range(0, 4) == 0) a = a + 32'($urandom_range(1, 3));
         if ($urandom_range(0, 9) == 0) a = 32'h3FFF_FFF0 + 32'($urandom_range(0, 3) * 4);
         axi_write(a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 2), model_resp(a), 1'b0, $sformatf("rnd%0d", t));
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
